// File: rtl/spi_regbank.sv
// SPI mode-0 slave register bank: NUM_OUT_REGS R/W control registers followed by
// NUM_IN_REGS read-only status registers, with burst auto-increment and access strobes.
module spi_regbank #(
  parameter int unsigned                        NUM_OUT_REGS = 8,
  parameter int unsigned                        NUM_IN_REGS  = 4,
  parameter int unsigned                        DATA_W       = 8,
  parameter int unsigned                        AUTO_INC     = 1,
  parameter logic [NUM_OUT_REGS*DATA_W-1:0]     OUT_RESET    = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               spi_cs_n,
  input  logic                               spi_clk,
  input  logic                               spi_mosi,
  output logic                               spi_miso,
  output logic                               spi_miso_oe,
  input  logic [NUM_IN_REGS*DATA_W-1:0]      in_regs,
  output logic [NUM_OUT_REGS*DATA_W-1:0]     out_regs,
  output logic [NUM_OUT_REGS-1:0]            wr_stb,
  output logic [NUM_IN_REGS-1:0]             rd_stb,
  output logic                               busy
);

  localparam int unsigned NumRegs  = NUM_OUT_REGS + NUM_IN_REGS;
  localparam logic [6:0]  LastAddr = 7'(NumRegs - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWr, StRd} state_e;

  logic [1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic       cs_prev_q, sclk_prev_q;

  state_e                            state_q, state_d;
  logic [2:0]                        cnt_q, cnt_d;
  logic [6:0]                        shin_q, shin_d;
  logic [6:0]                        addr_q, addr_d;
  logic [DATA_W-1:0]                 shout_q, shout_d;
  logic                              miso_q, miso_d;
  logic [NUM_OUT_REGS*DATA_W-1:0]    out_q, out_d;
  logic [NUM_OUT_REGS-1:0]           wr_stb_q, wr_stb_d;
  logic [NUM_IN_REGS-1:0]            rd_stb_q, rd_stb_d;

  logic              cs_low, cs_fall, sclk_rise, sclk_fall, load;
  logic [7:0]        rx_byte;
  logic [6:0]        addr_inc, load_addr;
  logic [DATA_W-1:0] rd_val;

  // Pin synchronisers and edge history; unreset so a frame cut by reset never looks like a new cs_n fall.
  always_ff @(posedge clk) begin
    cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
    sclk_sync_q <= {sclk_sync_q[0], spi_clk};
    mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    cs_prev_q   <= cs_sync_q[1];
    sclk_prev_q <= sclk_sync_q[1];
  end

  assign cs_low    = ~cs_sync_q[1];
  assign cs_fall   = cs_prev_q & ~cs_sync_q[1];
  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign rx_byte   = {shin_q, mosi_sync_q[1]};

  assign addr_inc  = (AUTO_INC == 0) ? addr_q :
                     (addr_q == LastAddr) ? 7'd0 : addr_q + 7'd1;
  // The command byte supplies the first read address; later loads prefetch the next one.
  assign load_addr = (state_q == StCmd) ? rx_byte[6:0] : addr_inc;

  // Register-file read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_OUT_REGS; k++) begin
      if (load_addr == 7'(k)) rd_val = out_q[k*DATA_W +: DATA_W];
    end
    for (int k = 0; k < NUM_IN_REGS; k++) begin
      if (load_addr == 7'(NUM_OUT_REGS + k)) rd_val = in_regs[k*DATA_W +: DATA_W];
    end
  end

  // Frame FSM next-state, shifting, register writes and strobes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shin_d   = shin_q;
    addr_d   = addr_q;
    shout_d  = shout_q;
    miso_d   = miso_q;
    out_d    = out_q;
    wr_stb_d = '0;
    rd_stb_d = '0;
    load     = 1'b0;

    if (!cs_low) begin
      // cs_n high wins over any spi_clk edge seen in the same cycle.
      state_d = StIdle;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end
        default: begin
          if (sclk_rise) begin
            shin_d = rx_byte[6:0];
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              unique case (state_q)
                StCmd: begin
                  addr_d = rx_byte[6:0];
                  miso_d = 1'b0;
                  if (rx_byte[7]) begin
                    state_d = StRd;
                    load    = 1'b1;
                  end else begin
                    state_d = StWr;
                  end
                end
                StWr: begin
                  for (int k = 0; k < NUM_OUT_REGS; k++) begin
                    if (addr_q == 7'(k)) begin
                      out_d[k*DATA_W +: DATA_W] = rx_byte[DATA_W-1:0];
                      wr_stb_d[k]               = 1'b1;
                    end
                  end
                  addr_d = addr_inc;
                end
                StRd: begin
                  addr_d = addr_inc;
                  load   = 1'b1;
                end
                default: ;
              endcase
            end
          end else if (sclk_fall && state_q == StRd) begin
            miso_d  = shout_q[DATA_W-1];
            shout_d = {shout_q[DATA_W-2:0], 1'b0};
          end
          if (load) begin
            shout_d = rd_val;
            for (int k = 0; k < NUM_IN_REGS; k++) begin
              if (load_addr == 7'(NUM_OUT_REGS + k)) rd_stb_d[k] = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      shin_q   <= '0;
      addr_q   <= '0;
      shout_q  <= '0;
      miso_q   <= 1'b0;
      out_q    <= OUT_RESET;
      wr_stb_q <= '0;
      rd_stb_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shin_q   <= shin_d;
      addr_q   <= addr_d;
      shout_q  <= shout_d;
      miso_q   <= miso_d;
      out_q    <= out_d;
      wr_stb_q <= wr_stb_d;
      rd_stb_q <= rd_stb_d;
    end
  end

  assign spi_miso_oe = (state_q == StRd);
  assign spi_miso    = miso_q & spi_miso_oe;
  assign busy        = (state_q != StIdle);
  assign out_regs    = out_q;
  assign wr_stb      = wr_stb_q;
  assign rd_stb      = rd_stb_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Randomised scoreboard bench for spi_regbank (8 out regs, 4 in regs, auto-increment).
module tb_spi_regbank;

  localparam logic [63:0] RstVal = 64'h8877665544332211;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_n, spi_clk, spi_mosi;
  logic        spi_miso, spi_miso_oe, busy;
  logic [31:0] in_regs;
  logic [63:0] out_regs;
  logic [7:0]  wr_stb;
  logic [3:0]  rd_stb;

  spi_regbank #(
    .NUM_OUT_REGS(8),
    .NUM_IN_REGS (4),
    .DATA_W      (8),
    .AUTO_INC    (1),
    .OUT_RESET   (RstVal)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .in_regs    (in_regs),
    .out_regs   (out_regs),
    .wr_stb     (wr_stb),
    .rd_stb     (rd_stb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         wr_q[$];
  int          rds_q[$];
  logic [7:0]  rdd_q[$];
  logic [63:0] snap_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  model_out[8];
  bit          done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  // ---------------- reference model ----------------
  function automatic int nxt(input int a);
    return (a == 11) ? 0 : (a + 1) % 128;
  endfunction

  function automatic logic [7:0] model_rd(input int a);
    if (a < 8) return model_out[a];
    if (a < 12) return in_regs[(a-8)*8 +: 8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = model_out[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) model_out[k] = RstVal[k*8 +: 8];
  endtask

  // ---------------- SPI master ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wait_clk(5);
      spi_clk = 1'b1;
      wait_clk(5);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_start();
    spi_cs_n = 1'b0;
    wait_clk(5);
  endtask

  task automatic frame_end();
    wait_clk(5);
    spi_cs_n = 1'b1;
    wait_clk(10);
  endtask

  task automatic push_snap();
    snap_q.push_back(model_vec());
    wait_clk(2);
  endtask

  // Write frame using the bytes queued in data_q; optional trailing partial byte.
  task automatic wr_frame(input int addr, input int partial_bits);
    int a;
    logic [7:0] b;
    a = addr;
    frame_start();
    spi_bits({1'b0, 7'(addr)}, 8);
    while (data_q.size() > 0) begin
      b = data_q.pop_front();
      if (a < 8) begin
        model_out[a] = b;
        wr_q.push_back({7'(a), b});
      end
      spi_bits(b, 8);
      a = nxt(a);
    end
    if (partial_bits > 0) spi_bits(8'($urandom), partial_bits);
    frame_end();
    push_snap();
  endtask

  // Read frame of n data bytes; every load (including the final prefetch) of an in_reg strobes.
  task automatic rd_frame(input int addr, input int n);
    int a;
    a = addr;
    frame_start();
    if (a >= 8 && a < 12) rds_q.push_back(a - 8);
    spi_bits({1'b1, 7'(addr)}, 8);
    for (int i = 0; i < n; i++) begin
      rdd_q.push_back(model_rd(a));
      a = nxt(a);
      if (a >= 8 && a < 12) rds_q.push_back(a - 8);
      spi_bits(8'($urandom), 8);
    end
    frame_end();
    push_snap();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    in_regs  = 32'h0;
    wait_clk(5);
    reset = 1'b0;
    wait_clk(2);
    model_reset();
    push_snap();

    data_q = '{8'hA5};
    wr_frame(2, 0);

    data_q = '{8'h11, 8'h22, 8'h33};
    wr_frame(6, 0);

    in_regs = 32'h0000_5C00;
    rd_frame(9, 1);
    rd_frame(127, 2);

    in_regs = $urandom;
    rd_frame(11, 3);

    // Partial data byte after a complete one.
    data_q = '{8'h3C};
    wr_frame(1, 5);

    // Reset in the middle of a write frame; rest of frame must be ignored.
    frame_start();
    spi_bits(8'h03, 8);
    spi_bits(8'hFF, 4);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    spi_bits(8'hFF, 4);
    spi_bits(8'hEE, 8);
    frame_end();
    model_reset();
    push_snap();

    data_q = '{8'h5A};
    wr_frame(2, 0);

    for (int t = 0; t < 24; t++) begin
      int a;
      int n;
      in_regs = $urandom;
      a = $urandom_range(0, 13);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        rd_frame(a, n);
      end else begin
        for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
        wr_frame(a, 0);
      end
    end
    wait_clk(5);
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int         cyc;
    int         bitn;
    logic       sclk_prev;
    logic [7:0] rx;
    wr_t        e;
    int         ri;
    logic [7:0] rexp;
    logic [63:0] sexp;
    cyc       = 0;
    bitn      = 0;
    sclk_prev = 1'b0;
    rx        = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 80000) begin
        errors++;
        $display("FAIL watchdog: cycles=%0d limit=80000", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end

      if (wr_stb != 8'h00) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_stb_unexpected: got=%h expected=00", wr_stb);
        end else begin
          e = wr_q.pop_front();
          if (wr_stb !== (8'd1 << e.addr) || out_regs[8*e.addr +: 8] !== e.data) begin
            errors++;
            $display("FAIL wr_stb: got stb=%h reg=%h expected stb=%h reg=%h", wr_stb,
                     out_regs[8*e.addr +: 8], 8'd1 << e.addr, e.data);
          end
        end
      end

      if (rd_stb != 4'h0) begin
        checks++;
        if (rds_q.size() == 0) begin
          errors++;
          $display("FAIL rd_stb_unexpected: got=%h expected=0", rd_stb);
        end else begin
          ri = rds_q.pop_front();
          if (rd_stb !== (4'd1 << ri)) begin
            errors++;
            $display("FAIL rd_stb: got=%h expected=%h", rd_stb, 4'd1 << ri);
          end
        end
      end

      if (spi_cs_n) begin
        bitn = 0;
      end else if (spi_clk && !sclk_prev && spi_miso_oe) begin
        rx = {rx[6:0], spi_miso};
        bitn++;
        if (bitn == 8) begin
          bitn = 0;
          checks++;
          if (rdd_q.size() == 0) begin
            errors++;
            $display("FAIL rd_data_unexpected: got=%h", rx);
          end else begin
            rexp = rdd_q.pop_front();
            if (rx !== rexp) begin
              errors++;
              $display("FAIL rd_data: got=%h expected=%h", rx, rexp);
            end
          end
        end
      end
      sclk_prev = spi_clk;

      if (snap_q.size() > 0) begin
        sexp = snap_q.pop_front();
        checks++;
        if (out_regs !== sexp || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || busy !== 1'b0
            || wr_stb !== 8'h00 || rd_stb !== 4'h0) begin
          errors++;
          $display("FAIL idle_state: got regs=%h oe=%b miso=%b busy=%b wr=%h rd=%h expected regs=%h oe=0 miso=0 busy=0 wr=00 rd=0",
                   out_regs, spi_miso_oe, spi_miso, busy, wr_stb, rd_stb, sexp);
        end
      end

      if (done) begin
        checks++;
        if (wr_q.size() != 0 || rds_q.size() != 0 || rdd_q.size() != 0) begin
          errors++;
          $display("FAIL pending: got wr=%0d rd_stb=%0d rd_data=%0d outstanding expected 0",
                   wr_q.size(), rds_q.size(), rdd_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule
